// File: rtl/cms_axis_trace_receiver.sv
// rtl/cms_axis_trace_receiver.sv - trace AXI-Stream receiver: buffers wide beats, serialises to OUT_WIDTH words, checks tlast framing
// Optional skid buffer for back-to-back beats is enabled by defining CMS_RX_SKID_EN.
module cms_axis_trace_receiver #(
  parameter int AXI_DATA_WIDTH = 1024,
  parameter int OUT_WIDTH      = 64,
  localparam int WORDS         = AXI_DATA_WIDTH / OUT_WIDTH,
  localparam int IDX_W         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                      S_AXIS_tlast,
  input  logic [31:0]               tlast_interval,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]          out_word_idx,
  output logic                      out_last,
  output logic [31:0]               beat_count,
  output logic [31:0]               packet_count,
  output logic                      framing_err,
  input  logic                      clr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WORDS-1:0][OUT_WIDTH-1:0] buf_q;
  logic                            last_q;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [31:0]                     beats_in_pkt;

  logic accept;
  logic last_word;
  logic load_active;
  logic load_skid;
  logic skid_to_active;
  logic set_err;
  logic [31:0] pkt_next;

`ifdef CMS_RX_SKID_EN
  logic [AXI_DATA_WIDTH-1:0] skid_q;
  logic                      skid_last_q;
  logic                      skid_full_q;
`endif

  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    S_AXIS_tready  = 1'b0;
    out_valid      = 1'b0;
    accept         = 1'b0;
    load_active    = 1'b0;
    load_skid      = 1'b0;
    skid_to_active = 1'b0;
    case (state_q)
      IDLE: begin
        S_AXIS_tready = 1'b1;
        accept        = S_AXIS_tvalid;
        if (accept) begin
          load_active = 1'b1;
          idx_d       = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
`ifdef CMS_RX_SKID_EN
        S_AXIS_tready = !skid_full_q;
`endif
        accept = S_AXIS_tvalid && S_AXIS_tready;
        if (out_ready && last_word) begin
          idx_d = '0;
`ifdef CMS_RX_SKID_EN
          // Refill the active buffer on the final-word edge so the next beat has no bubble.
          if (skid_full_q) begin
            skid_to_active = 1'b1;
          end else if (accept) begin
            load_active = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          if (out_ready) begin
            idx_d = idx_q + IDX_W'(1);
          end
`ifdef CMS_RX_SKID_EN
          load_skid = accept;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      idx_q <= idx_d;
      if (load_active) begin
        buf_q  <= S_AXIS_tdata;
        last_q <= S_AXIS_tlast;
`ifdef CMS_RX_SKID_EN
      end else if (skid_to_active) begin
        buf_q  <= skid_q;
        last_q <= skid_last_q;
`endif
      end
    end
  end

`ifdef CMS_RX_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q      <= '0;
      skid_last_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (load_skid) begin
      skid_q      <= S_AXIS_tdata;
      skid_last_q <= S_AXIS_tlast;
      skid_full_q <= 1'b1;
    end else if (skid_to_active) begin
      skid_full_q <= 1'b0;
    end
  end
`endif

  assign out_data     = buf_q[idx_q];
  assign out_word_idx = idx_q;
  assign out_last     = out_valid && last_word && last_q;

  // A tlast arriving early or late, or a missing tlast at the boundary, both flag an error.
  assign pkt_next = beats_in_pkt + 32'd1;
  assign set_err  = accept && (tlast_interval != 32'd0) &&
                    (S_AXIS_tlast ? (pkt_next != tlast_interval) : (pkt_next == tlast_interval));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count   <= '0;
      packet_count <= '0;
      beats_in_pkt <= '0;
      framing_err  <= 1'b0;
    end else begin
      if (accept) begin
        beat_count <= beat_count + 32'd1;
        if (S_AXIS_tlast) begin
          packet_count <= packet_count + 32'd1;
          beats_in_pkt <= '0;
        end else begin
          beats_in_pkt <= pkt_next;
        end
      end
      if (set_err) begin
        framing_err <= 1'b1;
      end else if (clr_err) begin
        framing_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cms_axis_trace_receiver.sv
// tb/tb_cms_axis_trace_receiver.sv - directed table-driven bench for cms_axis_trace_receiver
`timescale 1ns/1ps
module tb_cms_axis_trace_receiver;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          S_AXIS_tvalid;
  logic          S_AXIS_tready;
  logic [1023:0] S_AXIS_tdata;
  logic          S_AXIS_tlast;
  logic [31:0]   tlast_interval;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [3:0]    out_word_idx;
  logic          out_last;
  logic [31:0]   beat_count;
  logic [31:0]   packet_count;
  logic          framing_err;
  logic          clr_err;

  int n_vec = 0;
  int n_err = 0;

  cms_axis_trace_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .S_AXIS_tvalid  (S_AXIS_tvalid),
    .S_AXIS_tready  (S_AXIS_tready),
    .S_AXIS_tdata   (S_AXIS_tdata),
    .S_AXIS_tlast   (S_AXIS_tlast),
    .tlast_interval (tlast_interval),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_word_idx   (out_word_idx),
    .out_last       (out_last),
    .beat_count     (beat_count),
    .packet_count   (packet_count),
    .framing_err    (framing_err),
    .clr_err        (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        last;
    logic [31:0] ivl;
    int          clr;      // 0 none, 1 pulse before beat, 2 held during acceptance
    logic        exp_err;
    logic [31:0] exp_bc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] make_beat(input int seed);
    logic [1023:0] r;
    for (int w = 0; w < 16; w++) r[w*64 +: 64] = {seed[31:0], w[31:0]};
    return r;
  endfunction

  task automatic send_beat(input logic [1023:0] data, input logic last, input logic clr);
    int budget = 0;
    @(negedge clk);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = data;
    S_AXIS_tlast  = last;
    clr_err       = clr;
    while (!S_AXIS_tready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!S_AXIS_tready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_beat_timeout: tready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    S_AXIS_tvalid = 1'b0;
    clr_err       = 1'b0;
  endtask

  task automatic drain(input logic [1023:0] data, input logic last, input int mode, input int nwords);
    int w = 0;
    int cyc = 0;
    while (w < nwords && cyc < 200) begin
      @(negedge clk);
      check("out_valid", {63'd0, out_valid}, 64'd1);
      check("out_data", out_data, data[w*64 +: 64]);
      check("out_word_idx", {60'd0, out_word_idx}, {60'd0, w[3:0]});
      check("out_last", {63'd0, out_last}, {63'd0, (last && w == 15)});
`ifndef CMS_RX_SKID_EN
      check("tready_in_drain", {63'd0, S_AXIS_tready}, 64'd0);
`endif
      out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      @(posedge clk);
      if (out_ready) w++;
      cyc++;
    end
    if (w < nwords) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d words expected %0d", w, nwords);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err_clears", {63'd0, framing_err}, 64'd0);
  endtask

  initial begin
    logic [1023:0] beat;
    logic [1023:0] exp_beat;
    int db, mb, mw, gaps;
    logic started, done, acc;
    longint t_first, t_last;

    tbl[0]  = '{1'b0, 32'd4, 0, 1'b0, 32'd3,  32'd2};
    tbl[1]  = '{1'b0, 32'd4, 0, 1'b0, 32'd4,  32'd2};
    tbl[2]  = '{1'b1, 32'd4, 0, 1'b1, 32'd5,  32'd3};
    tbl[3]  = '{1'b0, 32'd4, 1, 1'b0, 32'd6,  32'd3};
    tbl[4]  = '{1'b0, 32'd4, 0, 1'b0, 32'd7,  32'd3};
    tbl[5]  = '{1'b0, 32'd4, 0, 1'b0, 32'd8,  32'd3};
    tbl[6]  = '{1'b1, 32'd4, 0, 1'b0, 32'd9,  32'd4};
    tbl[7]  = '{1'b0, 32'd2, 0, 1'b0, 32'd10, 32'd4};
    tbl[8]  = '{1'b0, 32'd2, 0, 1'b1, 32'd11, 32'd4};
    tbl[9]  = '{1'b1, 32'd2, 0, 1'b1, 32'd12, 32'd5};
    tbl[10] = '{1'b0, 32'd0, 1, 1'b0, 32'd13, 32'd5};
    tbl[11] = '{1'b0, 32'd0, 0, 1'b0, 32'd14, 32'd5};
    tbl[12] = '{1'b0, 32'd0, 0, 1'b0, 32'd15, 32'd5};
    tbl[13] = '{1'b0, 32'd0, 0, 1'b0, 32'd16, 32'd5};
    tbl[14] = '{1'b0, 32'd0, 0, 1'b0, 32'd17, 32'd5};
    tbl[15] = '{1'b0, 32'd0, 0, 1'b0, 32'd18, 32'd5};
    tbl[16] = '{1'b1, 32'd0, 0, 1'b0, 32'd19, 32'd6};
    tbl[17] = '{1'b0, 32'd1, 2, 1'b1, 32'd20, 32'd6};
    tbl[18] = '{1'b1, 32'd1, 1, 1'b1, 32'd21, 32'd7};
    tbl[19] = '{1'b1, 32'd1, 1, 1'b0, 32'd22, 32'd8};

    rst_n          = 1'b0;
    S_AXIS_tvalid  = 1'b0;
    S_AXIS_tdata   = '0;
    S_AXIS_tlast   = 1'b0;
    tlast_interval = 32'd1;
    out_ready      = 1'b1;
    clr_err        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_idx", {60'd0, out_word_idx}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_beat_count", {32'd0, beat_count}, 64'd0);
    check("rst_packet_count", {32'd0, packet_count}, 64'd0);
    check("rst_framing_err", {63'd0, framing_err}, 64'd0);
    rst_n = 1'b1;

    // Single beat, words 0x00..0x0F
    beat = make_beat(0);
    send_beat(beat, 1'b1, 1'b0);
    drain(beat, 1'b1, 0, 16);
    @(negedge clk);
    check("b1_out_valid_idle", {63'd0, out_valid}, 64'd0);
    check("b1_beat_count", {32'd0, beat_count}, 64'd1);
    check("b1_packet_count", {32'd0, packet_count}, 64'd1);
    check("b1_framing_err", {63'd0, framing_err}, 64'd0);

    // Backpressure: out_ready alternates
    beat = make_beat(32'h0000_0BB0);
    send_beat(beat, 1'b1, 1'b0);
    drain(beat, 1'b1, 1, 16);
    @(negedge clk);
    check("bp_tready_after", {63'd0, S_AXIS_tready}, 64'd1);
    check("bp_beat_count", {32'd0, beat_count}, 64'd2);

    for (int i = 0; i < 20; i++) begin
      tlast_interval = tbl[i].ivl;
      if (tbl[i].clr == 1) pulse_clr();
      beat = make_beat(100 + i);
      send_beat(beat, tbl[i].last, (tbl[i].clr == 2));
      drain(beat, tbl[i].last, 0, 16);
      @(negedge clk);
      check($sformatf("tbl%0d_framing_err", i), {63'd0, framing_err}, {63'd0, tbl[i].exp_err});
      check($sformatf("tbl%0d_beat_count", i), {32'd0, beat_count}, {32'd0, tbl[i].exp_bc});
      check($sformatf("tbl%0d_packet_count", i), {32'd0, packet_count}, {32'd0, tbl[i].exp_pc});
    end

    // Continuous traffic: 8 back-to-back beats
    tlast_interval = 32'd0;
    out_ready = 1'b1;
    db = 0; mb = 0; mw = 0; gaps = 0;
    started = 1'b0; done = 1'b0;
    t_first = 0; t_last = 0;
    @(posedge clk);
    #1;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tlast  = 1'b0;
    S_AXIS_tdata  = make_beat(200);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (out_valid) begin
        started = 1'b1;
        exp_beat = make_beat(200 + mb);
        check("cont_out_data", out_data, exp_beat[mw*64 +: 64]);
        if (out_ready) begin
          if (mb == 7 && mw == 15) begin
            t_last = $time + 5;
            done = 1'b1;
          end else if (mw == 15) begin
            mw = 0;
            mb++;
          end else begin
            mw++;
          end
        end
      end else if (started) begin
        gaps++;
      end
      acc = S_AXIS_tvalid && S_AXIS_tready;
      if (acc && db == 0) t_first = $time + 5;
      @(posedge clk);
      #1;
      if (acc) begin
        db++;
        if (db < 8) S_AXIS_tdata = make_beat(200 + db);
        else S_AXIS_tvalid = 1'b0;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL cont_timeout: got %0d beats drained expected 8", mb);
    end
`ifdef CMS_RX_SKID_EN
    check("cont_cycles", 64'((t_last - t_first) / 10 + 1), 64'd129);
    check("cont_gaps", 64'(gaps), 64'd0);
`else
    check("cont_cycles", 64'((t_last - t_first) / 10 + 1), 64'd136);
    check("cont_gaps", 64'(gaps), 64'd7);
`endif
    @(negedge clk);
    check("cont_beat_count", {32'd0, beat_count}, 64'd30);

    // Reset while word 5 is presented
    beat = make_beat(32'h55);
    send_beat(beat, 1'b1, 1'b0);
    drain(beat, 1'b1, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_beat_count", {32'd0, beat_count}, 64'd0);
    check("mrst_packet_count", {32'd0, packet_count}, 64'd0);
    check("mrst_out_idx", {60'd0, out_word_idx}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle_valid", {63'd0, out_valid}, 64'd0);
    beat = make_beat(32'h66);
    send_beat(beat, 1'b0, 1'b0);
    drain(beat, 1'b0, 0, 16);
    @(negedge clk);
    check("mrst_beat_count_after", {32'd0, beat_count}, 64'd1);
    check("mrst_packet_count_after", {32'd0, packet_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
